ifetch_queue: RTL and testbench

Instruction fetch front end for the rv32i core. It generates sequential fetch addresses toward instruction memory over a valid/ready request channel with in-order, variable-latency responses, and buffers returned words in a small prefetch FIFO. It presents `{pc, instruction}` pairs to the decode stage. On a control-flow redirect it flushes the FIFO and discards every response still in flight.

---
 rtl/ifetch_queue.sv | 151 +++++++++++++++
 tb/tb_ifetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch front end with a prefetch FIFO.
// Issues word-aligned fetch requests under a credit rule (in-flight plus
// buffered never exceeds DEPTH), tags in-order responses with their PC and
// presents {pc, instruction} to decode. A redirect flushes the FIFO and
// marks every request still outstanding as stale so its response is dropped.
// Optional feature: define IFETCH_BYPASS_EN to forward a kept response
// straight to the decode outputs when the FIFO is empty (0-cycle latency).
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    localparam cnt_t          DEPTH_C = cnt_t'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0] fetch_pc;
    logic [31:0] rsp_pc;
    cnt_t        in_flight;
    cnt_t        drop_cnt;
    cnt_t        count;
    ptr_t        head;
    ptr_t        tail;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic [CW:0] credit_used;
    logic        req_fire;
    logic        rsp_keep;
    logic        bypass;
    logic        head_valid;
    logic        push;
    logic        pop;
    cnt_t        in_flight_next;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & ~32'h0000_0003;

    // Credit rule: a FIFO slot is reserved for every outstanding request.
    assign credit_used   = {1'b0, in_flight} + {1'b0, count};
    assign mem_req_valid = !redirect_valid && (credit_used < DEPTH_W);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response is kept only when no stale words remain and no redirect is
    // being taken this cycle.
    assign rsp_keep      = mem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

    assign in_flight_next = in_flight + cnt_t'(req_fire) - cnt_t'(mem_rsp_valid);

    assign head_valid = (count != '0);

`ifdef IFETCH_BYPASS_EN
    assign bypass = rsp_keep && !head_valid;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid = head_valid || bypass;

    // A bypassed word taken by decode in the same cycle never enters the FIFO.
    assign push = rsp_keep && !(bypass && inst_ready);
    assign pop  = head_valid && inst_ready;

    // Decode-side output mux: head entry, bypassed response, or zeros when empty.
    always_comb begin
        inst_pc   = '0;
        inst_data = '0;
        if (head_valid) begin
            inst_pc   = pc_mem[head];
            inst_data = data_mem[head];
        end else if (bypass) begin
            inst_pc   = rsp_pc;
            inst_data = mem_rsp_data;
        end
    end

    // Fetch/response bookkeeping and FIFO pointers; redirect overrides all else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc  <= RESET_PC;
            rsp_pc    <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
        end else begin
            in_flight <= in_flight_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                drop_cnt <= in_flight_next;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (mem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - cnt_t'(1);
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (push) begin
                    tail <= tail + ptr_t'(1);
                end
                if (pop) begin
                    head <= head + ptr_t'(1);
                end
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= rsp_pc;
            data_mem[tail] <= mem_rsp_data;
        end
    end

    rsp_into_full_fifo: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(mem_rsp_valid && (count == DEPTH_C))
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: random memory latency, decode back-pressure and
// redirects, checked against a request-level reference model. Every accepted
// request carries its own address and data; a kept response must reappear at
// the decode port as {request address, data} in order.
`timescale 1ns/1ps
module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk            = 1'b0;
    logic        reset_n        = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready  = 1'b0;
    logic        mem_rsp_valid  = 1'b0;
    logic [31:0] mem_rsp_data   = '0;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready     = 1'b0;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    req_t        pend[$];   // accepted, not yet answered requests
    ent_t        sb[$];     // expected decode stream
    logic [31:0] model_next = RESET_PC;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pops = 0;

    int unsigned lat_min = 1, lat_max = 1;
    int unsigned p_ready = 100, p_mready = 100, p_redir = 0;
    bit          redir_force = 1'b0;
    logic [31:0] redir_target = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus driver and in-order memory: inputs change 1ns after the edge.
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            inst_ready     = 1'b0;
            mem_req_ready  = 1'b0;
            redirect_valid = 1'b0;
            mem_rsp_valid  = 1'b0;
        end else begin
            inst_ready    = ($urandom_range(99) < p_ready);
            mem_req_ready = ($urandom_range(99) < p_mready);
            if (redir_force) begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_target;
                redir_force    = 1'b0;
            end else if ($urandom_range(999) < p_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom_range(1) ? $urandom : (32'hFFFF_FFE0 | 32'($urandom_range(31)));
            end else begin
                redirect_valid = 1'b0;
                redirect_pc    = $urandom;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = pend[0].data;
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = $urandom;
            end
        end
    end

    // Monitor and reference model: compare outputs, then advance the model
    // by the events that the coming edge commits.
    always @(negedge clk) begin
        req_t r;
        ent_t head_e;
        bit   keep, exp_valid, exp_req, took_bypass;
        int   outstanding;
        if (reset_n) begin
            keep        = 1'b0;
            took_bypass = 1'b0;
            outstanding = pend.size();
            exp_req     = !redirect_valid && (outstanding + sb.size() < DEPTH);
            if (mem_rsp_valid) begin
                if (pend.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rsp_without_request: got 1 required 0 (cycle %0d)", cyc);
                end else begin
                    r    = pend.pop_front();
                    keep = !r.stale && !redirect_valid;
                end
            end
            exp_valid = (sb.size() > 0);
            if (exp_valid) head_e = sb[0];
`ifdef IFETCH_BYPASS_EN
            else if (keep) begin
                exp_valid   = 1'b1;
                head_e.pc   = r.addr;
                head_e.data = r.data;
            end
`endif
            chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("inst_pc", inst_pc, head_e.pc);
                chk("inst_data", inst_data, head_e.data);
            end else begin
                chk("inst_pc_empty", inst_pc, 32'h0);
                chk("inst_data_empty", inst_data, 32'h0);
            end
            chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
            chk("mem_req_addr", mem_req_addr, model_next);

            if (redirect_valid) begin
                sb.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                model_next = redirect_pc & ~32'h3;
            end else begin
                if (exp_valid && inst_ready) begin
                    n_pops++;
                    if (sb.size() > 0) void'(sb.pop_front());
                    else took_bypass = 1'b1;
                end
                if (keep && !took_bypass) begin
                    ent_t e;
                    e.pc   = r.addr;
                    e.data = r.data;
                    sb.push_back(e);
                end
                if (exp_req && mem_req_ready) begin
                    req_t q;
                    q.addr  = model_next;
                    q.data  = $urandom;
                    q.due   = cyc + $urandom_range(lat_max, lat_min);
                    q.stale = 1'b0;
                    pend.push_back(q);
                    model_next = model_next + 32'd4;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_inst_valid", 32'(inst_valid), 32'h0);
        chk("reset_inst_pc", inst_pc, 32'h0);
        chk("reset_inst_data", inst_data, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // 1-cycle memory, decode always ready
        repeat (40) @(posedge clk);

        // decode stalled: FIFO fills, requests stop; then drain
        p_ready = 0;
        repeat (20) @(posedge clk);
        p_ready = 100;
        repeat (20) @(posedge clk);

        // 3-cycle memory, redirect with requests outstanding
        lat_min = 3; lat_max = 3;
        repeat (12) @(posedge clk);
        redir_target = 32'h8000_0103;
        redir_force  = 1'b1;
        repeat (25) @(posedge clk);

        // address wrap past 0xFFFF_FFFC
        lat_min = 1; lat_max = 1;
        redir_target = 32'hFFFF_FFF4;
        redir_force  = 1'b1;
        repeat (25) @(posedge clk);

        // randomized traffic
        lat_min = 1; lat_max = 5;
        p_ready = 60; p_mready = 70; p_redir = 30;
        repeat (3000) @(posedge clk);

        @(negedge clk);
        n_cmp++;
        if (n_pops < 200) begin
            n_err++;
            $display("FAIL progress: got %0d instructions required at least 200", n_pops);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
